hazard_stall_controller: RTL and testbench

- Decode-stage hazard unit that produces the stall and flush controls consumed by the IF/ID pipeline register (Stall_ID, PCSel) and by the PC and ID/EX register.
- Detects load-use hazards and decode-resolved-branch operand hazards.
- Runs a small FSM so that 2-cycle stalls are held without re-evaluating the inputs.
- Issues a 1-cycle IF/ID flush on a taken branch.

---
 rtl/hazard_stall_controller_if.sv | 58 +++++
 rtl/hazard_stall_controller.sv | 124 ++++++++++++
 tb/tb_hazard_stall_controller.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_controller_if
// Purpose  : Decode-stage hazard bus. Pipeline-side signals in, stall/flush
//            controls out. Counter signals exist only with HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_stall_controller_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] Rs_ID;
    logic [REG_ADDR_W-1:0] Rt_ID;
    logic                  UsesRs_ID;
    logic                  UsesRt_ID;
    logic                  IsBranch_ID;
    logic                  BranchTaken_ID;
    logic                  MemRead_EX;
    logic                  RegWrite_EX;
    logic [REG_ADDR_W-1:0] WriteReg_EX;
    logic                  MemRead_MEM;
    logic [REG_ADDR_W-1:0] WriteReg_MEM;

    logic                  Stall_ID;
    logic                  PCWrite;
    logic                  PCSel;
    logic                  Bubble_EX;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]      StallCycles;
    logic [CNT_W-1:0]      FlushCount;

    modport master (
        output Rs_ID, Rt_ID, UsesRs_ID, UsesRt_ID, IsBranch_ID, BranchTaken_ID,
               MemRead_EX, RegWrite_EX, WriteReg_EX, MemRead_MEM, WriteReg_MEM,
        input  Stall_ID, PCWrite, PCSel, Bubble_EX, StallCycles, FlushCount
    );

    modport slave (
        input  Rs_ID, Rt_ID, UsesRs_ID, UsesRt_ID, IsBranch_ID, BranchTaken_ID,
               MemRead_EX, RegWrite_EX, WriteReg_EX, MemRead_MEM, WriteReg_MEM,
        output Stall_ID, PCWrite, PCSel, Bubble_EX, StallCycles, FlushCount
    );
`else
    modport master (
        output Rs_ID, Rt_ID, UsesRs_ID, UsesRt_ID, IsBranch_ID, BranchTaken_ID,
               MemRead_EX, RegWrite_EX, WriteReg_EX, MemRead_MEM, WriteReg_MEM,
        input  Stall_ID, PCWrite, PCSel, Bubble_EX
    );

    modport slave (
        input  Rs_ID, Rt_ID, UsesRs_ID, UsesRt_ID, IsBranch_ID, BranchTaken_ID,
               MemRead_EX, RegWrite_EX, WriteReg_EX, MemRead_MEM, WriteReg_MEM,
        output Stall_ID, PCWrite, PCSel, Bubble_EX
    );
`endif
endinterface
`default_nettype wire

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_controller
// Purpose  : Decode-stage load-use / branch-operand hazard unit with a
//            RUN/HOLD FSM for 2-cycle stalls and a 1-cycle taken-branch flush.
//            Optional stall/flush counters: define HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_controller #(
    parameter int REG_ADDR_W = 5
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  wire logic                  Clock,
    input  wire logic                  Reset_n,
    hazard_stall_controller_if.slave   bus
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [REG_ADDR_W-1:0] c_ZERO_REG = '0;

    state_t r_state;
    state_t w_next_state;

    logic w_match_ex;
    logic w_match_mem;
    logic w_depth2;
    logic w_depth1;
    logic w_stall_raw;
    logic w_stall;
    logic w_flush;

    // Register 0 is hard-wired, so a write to it can never create a hazard.
    assign w_match_ex  = bus.RegWrite_EX && (bus.WriteReg_EX != c_ZERO_REG) &&
                         ((bus.UsesRs_ID && (bus.Rs_ID == bus.WriteReg_EX)) ||
                          (bus.UsesRt_ID && (bus.Rt_ID == bus.WriteReg_EX)));

    assign w_match_mem = bus.MemRead_MEM && (bus.WriteReg_MEM != c_ZERO_REG) &&
                         ((bus.UsesRs_ID && (bus.Rs_ID == bus.WriteReg_MEM)) ||
                          (bus.UsesRt_ID && (bus.Rt_ID == bus.WriteReg_MEM)));

    assign w_depth2 = bus.IsBranch_ID && bus.MemRead_EX && w_match_ex;

    assign w_depth1 = (bus.MemRead_EX && w_match_ex && !bus.IsBranch_ID) ||
                      (bus.IsBranch_ID && bus.RegWrite_EX && !bus.MemRead_EX && w_match_ex) ||
                      (bus.IsBranch_ID && w_match_mem);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Depth 2 is tested first so a simultaneous depth-1 condition resolves to it.
    always_comb begin
        w_next_state = r_state;
        w_stall_raw  = 1'b0;
        case (r_state)
            RUN: begin
                if (w_depth2) begin
                    w_stall_raw  = 1'b1;
                    w_next_state = HOLD;
                end else if (w_depth1) begin
                    w_stall_raw  = 1'b1;
                    w_next_state = RUN;
                end else begin
                    w_next_state = RUN;
                end
            end
            HOLD: begin
                w_stall_raw  = 1'b1;
                w_next_state = RUN;
            end
            default: begin
                w_stall_raw  = 1'b0;
                w_next_state = RUN;
            end
        endcase
    end

    // Outputs are combinational so the IF/ID register sees them this cycle;
    // reset overrides any hazard the inputs might still be showing.
    assign w_stall = Reset_n && w_stall_raw;
    assign w_flush = Reset_n && bus.BranchTaken_ID && !w_stall_raw;

    assign bus.Stall_ID  = w_stall;
    assign bus.Bubble_EX = w_stall;
    assign bus.PCWrite   = !w_stall;
    assign bus.PCSel     = w_flush;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != c_CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_flush && (r_flush_count != c_CNT_MAX)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign bus.StallCycles = r_stall_cycles;
    assign bus.FlushCount  = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_controller
// Purpose  : Scoreboard bench for hazard_stall_controller; expected output
//            vectors {Stall_ID,PCWrite,PCSel,Bubble_EX} are queued per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_controller;

    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 32;

    localparam logic [3:0] c_IDLE  = 4'b0100;
    localparam logic [3:0] c_STALL = 4'b1001;
    localparam logic [3:0] c_FLUSH = 4'b0110;

    logic Clock = 1'b0;
    logic Reset_n;

    always #5 Clock = ~Clock;

    hazard_stall_controller_if #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();

    hazard_stall_controller #(
        .REG_ADDR_W(REG_ADDR_W)
`ifdef HAZARD_PERF_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic       tk;
        logic       mrex;
        logic       rwex;
        logic [4:0] wex;
        logic       mrmem;
        logic [4:0] wmem;
    } stim_t;

    typedef struct {
        logic [3:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic stim_t zs();
        stim_t s;
        s.rs = '0; s.rt = '0; s.urs = 1'b0; s.urt = 1'b0; s.br = 1'b0; s.tk = 1'b0;
        s.mrex = 1'b0; s.rwex = 1'b0; s.wex = '0; s.mrmem = 1'b0; s.wmem = '0;
        return s;
    endfunction

    function automatic stim_t load_use();
        stim_t s = zs();
        s.mrex = 1'b1; s.rwex = 1'b1; s.wex = 5'd8; s.rs = 5'd8; s.urs = 1'b1;
        return s;
    endfunction

    function automatic stim_t br_after_load();
        stim_t s = zs();
        s.br = 1'b1; s.rt = 5'd9; s.urt = 1'b1; s.mrex = 1'b1; s.rwex = 1'b1; s.wex = 5'd9;
        return s;
    endfunction

    function automatic logic [3:0] observed();
        return {bus.Stall_ID, bus.PCWrite, bus.PCSel, bus.Bubble_EX};
    endfunction

    task automatic drive(input stim_t s);
        bus.Rs_ID = s.rs;            bus.Rt_ID = s.rt;
        bus.UsesRs_ID = s.urs;       bus.UsesRt_ID = s.urt;
        bus.IsBranch_ID = s.br;      bus.BranchTaken_ID = s.tk;
        bus.MemRead_EX = s.mrex;     bus.RegWrite_EX = s.rwex;
        bus.WriteReg_EX = s.wex;     bus.MemRead_MEM = s.mrmem;
        bus.WriteReg_MEM = s.wmem;
    endtask

    // Drive one cycle's inputs just after the falling edge and queue its expectation.
    task automatic apply(input stim_t s, input logic [3:0] e, input string name);
        exp_t x;
        @(negedge Clock);
        drive(s);
        x.v = e; x.name = name;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        exp_t x;
        logic [3:0] o;
        Reset_n = 1'b0;
        drive(br_after_load());
        x.v = c_IDLE; x.name = "reset_forced";
        sb.push_back(x);
        #2;
        x = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        repeat (2) @(posedge Clock);
        #1;
        x = sb.pop_front(); o = observed(); n_cmp++;
        x.v = c_IDLE; x.name = "reset_held";
        if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        @(negedge Clock);
        drive(zs());
        Reset_n = 1'b1;
    endtask

    task automatic test_load_use();
        stim_t s[4];
        logic [3:0] e[4];
        exp_t x;
        logic [3:0] o;
        s[0] = load_use();           e[0] = c_STALL;
        s[1] = load_use(); s[1].mrex = 1'b0; e[1] = c_IDLE;
        s[2] = zs();                 e[2] = c_IDLE;
        s[3] = load_use(); s[3].urs = 1'b0;  e[3] = c_IDLE;
        for (int i = 0; i < 4; i++) begin
            apply(s[i], e[i], $sformatf("load_use[%0d]", i));
            #2;
            x = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        end
    endtask

    task automatic test_branch_after_load();
        stim_t s[4];
        logic [3:0] e[4];
        exp_t x;
        logic [3:0] o;
        s[0] = br_after_load();      e[0] = c_STALL;
        s[1] = zs();                 e[1] = c_STALL;
        s[2] = zs();                 e[2] = c_IDLE;
        // HOLD ignores a taken branch on stale operands.
        s[3] = br_after_load();      e[3] = c_STALL;
        for (int i = 0; i < 4; i++) begin
            apply(s[i], e[i], $sformatf("br_load[%0d]", i));
            #2;
            x = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        end
        s[0] = zs(); s[0].tk = 1'b1; s[0].br = 1'b1;
        apply(s[0], c_STALL, "br_load_hold_taken");
        #2;
        x = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        apply(zs(), c_IDLE, "br_load_after");
        #2;
        x = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
    endtask

    task automatic test_branch_operands();
        stim_t s[6];
        logic [3:0] e[6];
        exp_t x;
        logic [3:0] o;
        s[0] = zs(); s[0].br = 1'b1; s[0].rwex = 1'b1; s[0].wex = 5'd4; s[0].rs = 5'd4; s[0].urs = 1'b1;
        e[0] = c_STALL;
        s[1] = zs();                 e[1] = c_IDLE;
        s[2] = zs(); s[2].br = 1'b1; s[2].mrmem = 1'b1; s[2].wmem = 5'd4; s[2].rs = 5'd4; s[2].urs = 1'b1;
        e[2] = c_STALL;
        s[3] = zs();                 e[3] = c_IDLE;
        s[4] = s[2]; s[4].br = 1'b0; e[4] = c_IDLE;
        s[5] = s[0]; s[5].rwex = 1'b0; e[5] = c_IDLE;
        for (int i = 0; i < 6; i++) begin
            apply(s[i], e[i], $sformatf("br_operand[%0d]", i));
            #2;
            x = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        end
    endtask

    task automatic test_reg_zero();
        stim_t s[2];
        logic [3:0] e[2];
        exp_t x;
        logic [3:0] o;
        s[0] = load_use(); s[0].wex = 5'd0; s[0].rs = 5'd0;            e[0] = c_IDLE;
        s[1] = br_after_load(); s[1].wex = 5'd0; s[1].rt = 5'd0;
        s[1].mrmem = 1'b1; s[1].wmem = 5'd0;                           e[1] = c_IDLE;
        for (int i = 0; i < 2; i++) begin
            apply(s[i], e[i], $sformatf("reg_zero[%0d]", i));
            #2;
            x = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        end
    endtask

    task automatic test_taken_branch();
        stim_t s[4];
        logic [3:0] e[4];
        exp_t x;
        logic [3:0] o;
        s[0] = zs(); s[0].br = 1'b1; s[0].tk = 1'b1; s[0].rs = 5'd3; s[0].urs = 1'b1;
        e[0] = c_FLUSH;
        s[1] = zs();                 e[1] = c_IDLE;
        s[2] = zs(); s[2].br = 1'b1; s[2].tk = 1'b1; s[2].rwex = 1'b1; s[2].wex = 5'd4;
        s[2].rs = 5'd4; s[2].urs = 1'b1;
        e[2] = c_STALL;
        s[3] = s[0];                 e[3] = c_FLUSH;
        for (int i = 0; i < 4; i++) begin
            apply(s[i], e[i], $sformatf("taken[%0d]", i));
            #2;
            x = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[6];
        logic [3:0] e[6];
        exp_t x;
        logic [3:0] o;
        // Depth 2 plus a MEM match at once still takes the 2-cycle path.
        s[0] = br_after_load(); s[0].mrmem = 1'b1; s[0].wmem = 5'd9; e[0] = c_STALL;
        s[1] = br_after_load();      e[1] = c_STALL;
        s[2] = br_after_load();      e[2] = c_STALL;
        s[3] = zs();                 e[3] = c_STALL;
        s[4] = load_use();           e[4] = c_STALL;
        s[5] = zs();                 e[5] = c_IDLE;
        for (int i = 0; i < 6; i++) begin
            apply(s[i], e[i], $sformatf("b2b[%0d]", i));
            #2;
            x = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        end
    endtask

    task automatic test_reset_in_hold();
        exp_t x;
        logic [3:0] o;
        apply(br_after_load(), c_STALL, "rst_hold_enter");
        #2;
        x = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        apply(zs(), c_STALL, "rst_hold_in_hold");
        #2;
        x = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        Reset_n = 1'b0;
        x.v = c_IDLE; x.name = "rst_hold_abort";
        sb.push_back(x);
        #1;
        x = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        @(negedge Clock);
        Reset_n = 1'b1;
        apply(zs(), c_IDLE, "rst_hold_release");
        #2;
        x = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
`ifdef HAZARD_PERF_CNT_EN
        n_cmp++;
        if (bus.StallCycles !== '0) begin
            n_err++; $display("FAIL rst_stall_cnt: got %0d required 0", bus.StallCycles);
        end
        n_cmp++;
        if (bus.FlushCount !== '0) begin
            n_err++; $display("FAIL rst_flush_cnt: got %0d required 0", bus.FlushCount);
        end
`endif
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_counters();
        stim_t s;
        exp_t x;
        logic [3:0] o;
        apply(br_after_load(), c_STALL, "cnt_stall0");
        #2;
        x = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        s = zs(); s.br = 1'b1; s.tk = 1'b1;
        apply(s, c_STALL, "cnt_stall1");
        #2;
        x = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        apply(s, c_FLUSH, "cnt_flush");
        #2;
        x = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== x.v) begin n_err++; $display("FAIL %s: got %b required %b", x.name, o, x.v); end
        @(negedge Clock);
        drive(zs());
        n_cmp++;
        if (bus.StallCycles !== 32'd2) begin
            n_err++; $display("FAIL cnt_stall: got %0d required 2", bus.StallCycles);
        end
        n_cmp++;
        if (bus.FlushCount !== 32'd1) begin
            n_err++; $display("FAIL cnt_flush: got %0d required 1", bus.FlushCount);
        end
    endtask
`endif

    initial begin
        drive(zs());
        test_reset();
        test_load_use();
        test_branch_after_load();
        test_branch_operands();
        test_reg_zero();
        test_taken_branch();
        test_back_to_back();
        test_reset_in_hold();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_counters();
`endif
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
